sad_line_accumulator: RTL and testbench
=======================================

# sad_line_accumulator

Downstream consumer of the registered image/template line buffer in the template-matching datapath. Each cycle that a valid line is presented, it computes the per-template sum of absolute differences (SAD) between the image line and each template line. It accumulates these SADs over `TEMPLATE_ROWS` lines, then reports every template's total score plus the index and score of the best (minimum-SAD) template.

## Interface
- `PIXEL_SIZE`, 8, bits per pixel (unsigned)
- `LINE_SIZE`, 8, pixels per line
- `NUM_TEMPLATES`, 4, templates compared in parallel
- `TEMPLATE_ROWS`, 8, lines per match window
- `CLK`  in  1  single clock, rising edge
- `RST_N`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle pulse: clear accumulators, begin a new window
- `line_valid`  in  1  `I_line`/`T_line` carry a valid line this cycle (already aligned to buffer output)
- `I_line`  in  `[PIXEL_SIZE-1:0]` x `LINE_SIZE`  image line
- `T_line`  in  `[PIXEL_SIZE-1:0]` x `LINE_SIZE` x `NUM_TEMPLATES`  template lines
- `sad_out`  out  `[ACC_W-1:0]` x `NUM_TEMPLATES`  per-template window SAD
- `best_idx`  out  `$clog2(NUM_TEMPLATES)`  index of minimum SAD
- `best_sad`  out  `ACC_W`  minimum SAD value
- `result_valid`  out  1  one-cycle pulse when results update
- `busy`  out  1  high from `start` until `result_valid`

## Operation
- Widths: `LSAD_W = PIXEL_SIZE + $clog2(LINE_SIZE)` (11 at defaults); `ACC_W = LSAD_W + $clog2(TEMPLATE_ROWS)` (14). All arithmetic is unsigned. Overflow is impossible by construction.
- Stage 1 (line SAD): for each template, compute the sum over pixels of |I−T|, using the subtract-and-select-sign absolute difference and an adder tree. Register the result together with a delayed valid.
- Stage 2 (accumulate): `acc[k] += lsad[k]` when the stage-1 valid is high and the state is ACCUM.
- Stage 3 (select): linear minimum search over `acc`. Ties resolve to the lowest index. `sad_out`, `best_idx` and `best_sad` are registered, and `result_valid` pulses with them.
- FSM states:
  - IDLE: `busy`=0; `line_valid` is ignored. On `start` → ACCUM, clear `acc` and `row_cnt`.
  - ACCUM: `row_cnt` increments on each `line_valid`. On the `TEMPLATE_ROWS`-th valid line → FLUSH.
  - FLUSH: wait for the pipeline to drain (stages 1–2), then → DONE.
  - DONE: load the stage-3 registers, pulse `result_valid`, → IDLE.
- Gaps in `line_valid` during ACCUM only stall counting; there is no timeout.
- `line_valid` in FLUSH or DONE is ignored; extra lines are dropped.
- `start` in any non-IDLE state restarts the window: clear `acc` and `row_cnt`, discard in-flight stage-1 data, go to ACCUM, and suppress the pending `result_valid`.
- `start` and `line_valid` in the same cycle: the line counts as row 0 of the new window.
- Outputs hold their last result until the next DONE.

## Timing
- Reset (`RST_N`=0, async): state = IDLE. All accumulators, `row_cnt`, `sad_out`, `best_idx`, `best_sad`, `result_valid` and `busy` are cleared to 0.
- Reset asserted mid-window aborts the window; no `result_valid` is produced.
- Latency: a line with `line_valid` at cycle n appears in the line SAD at n+1 and in `acc` at n+2.
- If the last valid line is at cycle L, `result_valid` is high exactly at L+3 and `busy` falls at L+4.
- `busy` rises the cycle after `start`.
- Throughput: one line per cycle. The minimum window length is `TEMPLATE_ROWS` cycles plus 3 cycles of drain.

## Structure
- The shared parameters package holds `PIXEL_SIZE`, `LINE_SIZE`, `NUM_TEMPLATES` and `TEMPLATE_ROWS`, the derived `LSAD_W`/`ACC_W`, and the FSM state enum `sad_state_t`.
- One sub-module, `line_sad`: combinational |I−T| plus adder tree for one template line, instantiated `NUM_TEMPLATES` times. Registering of its output stays in the parent.

## Test plan
- Image = 100 everywhere, templates = 100/98/105/90 constant, 8 contiguous lines → `sad_out` = 0/128/320/640, `best_idx`=0, `best_sad`=0, `result_valid` at L+3.
- Worst case: image = 255, template 2 = 0, others = 255 → `sad_out[2]` = 16320 with no overflow, and `best_idx`=0 (tie between templates 0, 1 and 3).
- Same stimulus as the first test, but `line_valid` asserted only every third cycle → identical results; `result_valid` exactly 3 cycles after the 8th valid line.
- `start` re-pulsed after 5 lines, then 8 fresh lines with template 3 = image → no intermediate `result_valid`; final `best_idx`=3, `best_sad`=0.
- `RST_N` pulsed low after 4 lines → all outputs 0 immediately, `busy`=0; later `line_valid` without `start` produces no result.
- 10 valid lines after `start` → only the first 8 are accumulated; lines 9–10 are ignored and a single `result_valid` is produced.

Source files
------------

// File: rtl/sad_line_accumulator_pkg.sv
// Shared sizing, types and helpers for the template-matching SAD accumulator.
// The line SAD and window SAD widths are sized so that the largest possible sum still fits.
package sad_line_accumulator_pkg;

   localparam int PIXEL_SIZE    = 8;
   localparam int LINE_SIZE     = 8;
   localparam int NUM_TEMPLATES = 4;
   localparam int TEMPLATE_ROWS = 8;

   localparam int LSAD_W = PIXEL_SIZE + $clog2(LINE_SIZE);
   localparam int ACC_W  = LSAD_W + $clog2(TEMPLATE_ROWS);
   localparam int IDX_W  = (NUM_TEMPLATES > 1) ? $clog2(NUM_TEMPLATES) : 1;
   localparam int ROW_W  = $clog2(TEMPLATE_ROWS + 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_FLUSH = 2'd2,
      ST_DONE  = 2'd3
   } sad_state_t;

   typedef logic [PIXEL_SIZE-1:0]     pixel_t;
   typedef pixel_t [LINE_SIZE-1:0]    line_t;
   typedef line_t [NUM_TEMPLATES-1:0] tpl_lines_t;
   typedef logic [LSAD_W-1:0]         lsad_t;
   typedef logic [ACC_W-1:0]          acc_t;
   typedef acc_t [NUM_TEMPLATES-1:0]  sad_vec_t;

   // Both differences are formed and the borrow of one picks the non-negative result.
   function automatic pixel_t abs_diff(input pixel_t a, input pixel_t b);
      logic [PIXEL_SIZE:0] d_ab;
      logic [PIXEL_SIZE:0] d_ba;
      d_ab = {1'b0, a} - {1'b0, b};
      d_ba = {1'b0, b} - {1'b0, a};
      return d_ab[PIXEL_SIZE] ? d_ba[PIXEL_SIZE-1:0] : d_ab[PIXEL_SIZE-1:0];
   endfunction

endpackage

// File: rtl/sad_line_accumulator_line_sad.sv
// Combinational SAD of one image line against one template line.
// The caller registers the result.
module line_sad
   import sad_line_accumulator_pkg::*;
(
   input  line_t i_img,
   input  line_t i_tpl,
   output lsad_t o_sad
);

   // Heap-ordered binary adder tree: leaves hold |I-T| per pixel, node i sums nodes 2i+1 and 2i+2.
   always_comb begin : adder_tree
      lsad_t node [2*LINE_SIZE-1];
      for (int i = 0; i < 2*LINE_SIZE-1; i++) begin
         node[i] = '0;
      end
      for (int p = 0; p < LINE_SIZE; p++) begin
         node[LINE_SIZE-1+p] = lsad_t'(abs_diff(i_img[p], i_tpl[p]));
      end
      for (int i = LINE_SIZE-2; i >= 0; i--) begin
         node[i] = node[2*i+1] + node[2*i+2];
      end
      o_sad = node[0];
   end

endmodule

// File: rtl/sad_line_accumulator.sv
// Accumulates per-template line SADs over a window of TEMPLATE_ROWS lines, then
// reports every window total together with the index and value of the smallest one.
module sad_line_accumulator
   import sad_line_accumulator_pkg::*;
(
   input  logic                  CLK,
   input  logic                  RST_N,
   input  logic                  start,
   input  logic                  line_valid,
   input  line_t                 I_line,
   input  tpl_lines_t            T_line,
   output sad_vec_t              sad_out,
   output logic [IDX_W-1:0]      best_idx,
   output acc_t                  best_sad,
   output logic                  result_valid,
   output logic                  busy
);

   sad_state_t         r_state;
   sad_state_t         w_state_next;
   logic [ROW_W-1:0]   r_row_cnt;
   logic [ROW_W-1:0]   w_row_base;
   logic [ROW_W-1:0]   w_row_next;
   logic               w_line_take;
   logic               w_last_line;

   lsad_t              w_lsad [NUM_TEMPLATES];
   lsad_t              r_lsad [NUM_TEMPLATES];
   logic               r_s1_valid;
   acc_t               r_acc  [NUM_TEMPLATES];

   logic [IDX_W-1:0]   w_min_idx;
   acc_t               w_min_sad;
   sad_vec_t           r_sad_out;
   logic [IDX_W-1:0]   r_best_idx;
   acc_t               r_best_sad;
   logic               r_result_valid;
   logic               r_busy;
   logic               w_load_result;

   for (genvar k = 0; k < NUM_TEMPLATES; k++) begin : g_line_sad
      line_sad u_line_sad (
         .i_img (I_line),
         .i_tpl (T_line[k]),
         .o_sad (w_lsad[k])
      );
   end

   // A start always opens a fresh window, so a line arriving with it becomes row 0.
   always_comb begin
      w_line_take  = line_valid && (start || (r_state == ST_ACCUM));
      w_row_base   = start ? '0 : r_row_cnt;
      w_last_line  = w_line_take && (w_row_base == ROW_W'(TEMPLATE_ROWS - 1));
      w_row_next   = w_line_take ? (w_row_base + 1'b1) : w_row_base;
      w_state_next = r_state;
      if (start) begin
         w_state_next = w_last_line ? ST_FLUSH : ST_ACCUM;
      end else begin
         case (r_state)
            ST_IDLE:  w_state_next = ST_IDLE;
            ST_ACCUM: w_state_next = w_last_line ? ST_FLUSH : ST_ACCUM;
            ST_FLUSH: w_state_next = ST_DONE;
            ST_DONE:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state   <= ST_IDLE;
         r_row_cnt <= '0;
      end else begin
         r_state   <= w_state_next;
         r_row_cnt <= w_row_next;
      end
   end

   // Stage 1 only marks lines that belong to the window; the last one is still in flight during FLUSH.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_s1_valid <= 1'b0;
         for (int k = 0; k < NUM_TEMPLATES; k++) begin
            r_lsad[k] <= '0;
         end
      end else begin
         r_s1_valid <= w_line_take;
         for (int k = 0; k < NUM_TEMPLATES; k++) begin
            r_lsad[k] <= w_lsad[k];
         end
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         for (int k = 0; k < NUM_TEMPLATES; k++) begin
            r_acc[k] <= '0;
         end
      end else if (start) begin
         for (int k = 0; k < NUM_TEMPLATES; k++) begin
            r_acc[k] <= '0;
         end
      end else if (r_s1_valid) begin
         for (int k = 0; k < NUM_TEMPLATES; k++) begin
            r_acc[k] <= r_acc[k] + acc_t'(r_lsad[k]);
         end
      end
   end

   // Strict less-than keeps the earliest template on ties.
   always_comb begin
      w_min_idx = '0;
      w_min_sad = r_acc[0];
      for (int k = 1; k < NUM_TEMPLATES; k++) begin
         if (r_acc[k] < w_min_sad) begin
            w_min_sad = r_acc[k];
            w_min_idx = IDX_W'(k);
         end
      end
   end

   assign w_load_result = (r_state == ST_DONE) && !start;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_sad_out      <= '0;
         r_best_idx     <= '0;
         r_best_sad     <= '0;
         r_result_valid <= 1'b0;
      end else begin
         r_result_valid <= w_load_result;
         if (w_load_result) begin
            for (int k = 0; k < NUM_TEMPLATES; k++) begin
               r_sad_out[k] <= r_acc[k];
            end
            r_best_idx <= w_min_idx;
            r_best_sad <= w_min_sad;
         end
      end
   end

   // Busy stays up through the result pulse and drops on the cycle after it.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_busy <= 1'b0;
      end else if (start) begin
         r_busy <= 1'b1;
      end else if (r_result_valid) begin
         r_busy <= 1'b0;
      end
   end

   assign sad_out      = r_sad_out;
   assign best_idx     = r_best_idx;
   assign best_sad     = r_best_sad;
   assign result_valid = r_result_valid;
   assign busy         = r_busy;

endmodule

// File: tb/tb_sad_line_accumulator.sv
// Self-checking bench: a behavioural window model pushes expected results to a
// scoreboard when the final line of a window is driven; a monitor pops them on result_valid.
module tb_sad_line_accumulator;
   import sad_line_accumulator_pkg::*;

   logic             CLK = 1'b0;
   logic             RST_N = 1'b1;
   logic             start = 1'b0;
   logic             line_valid = 1'b0;
   line_t            I_line = '0;
   tpl_lines_t       T_line = '0;
   sad_vec_t         sad_out;
   logic [IDX_W-1:0] best_idx;
   acc_t             best_sad;
   logic             result_valid;
   logic             busy;

   sad_line_accumulator dut (
      .CLK          (CLK),
      .RST_N        (RST_N),
      .start        (start),
      .line_valid   (line_valid),
      .I_line       (I_line),
      .T_line       (T_line),
      .sad_out      (sad_out),
      .best_idx     (best_idx),
      .best_sad     (best_sad),
      .result_valid (result_valid),
      .busy         (busy)
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc++;

   typedef struct {
      int sad [NUM_TEMPLATES];
      int idx;
      int best;
      int cyc;
   } exp_t;

   exp_t sbq [$];
   int   compared = 0;
   int   mismatched = 0;
   int   mAcc [NUM_TEMPLATES];
   int   mRows = 0;
   bit   mActive = 0;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      compared++;
      if (obs !== expv) begin
         mismatched++;
         $display("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, expv);
      end
   endtask

   function automatic line_t constLine(input int v);
      line_t l;
      for (int p = 0; p < LINE_SIZE; p++) l[p] = pixel_t'(v);
      return l;
   endfunction

   function automatic tpl_lines_t constTpl(input int v0, input int v1, input int v2, input int v3);
      tpl_lines_t t;
      t[0] = constLine(v0);
      t[1] = constLine(v1);
      t[2] = constLine(v2);
      t[3] = constLine(v3);
      return t;
   endfunction

   // Drives one cycle of inputs and advances the reference window model.
   task automatic applyStimulus(input line_t img, input tpl_lines_t tpl, input bit valid, input bit strt);
      exp_t e;
      int a, b;
      @(negedge CLK);
      I_line = img;
      T_line = tpl;
      line_valid = valid;
      start = strt;
      if (strt) begin
         mActive = 1;
         mRows = 0;
         for (int k = 0; k < NUM_TEMPLATES; k++) mAcc[k] = 0;
      end
      if (valid && mActive && mRows < TEMPLATE_ROWS) begin
         for (int k = 0; k < NUM_TEMPLATES; k++) begin
            for (int p = 0; p < LINE_SIZE; p++) begin
               a = int'(img[p]);
               b = int'(tpl[k][p]);
               mAcc[k] += (a > b) ? (a - b) : (b - a);
            end
         end
         mRows++;
         if (mRows == TEMPLATE_ROWS) begin
            e.idx = 0;
            e.best = mAcc[0];
            for (int k = 0; k < NUM_TEMPLATES; k++) begin
               e.sad[k] = mAcc[k];
               if (mAcc[k] < e.best) begin
                  e.best = mAcc[k];
                  e.idx = k;
               end
            end
            e.cyc = cyc + 3;
            sbq.push_back(e);
            mActive = 0;
         end
      end
   endtask

   task automatic releaseInputs();
      @(negedge CLK);
      line_valid = 1'b0;
      start = 1'b0;
   endtask

   task automatic waitDrain(input int budget);
      releaseInputs();
      for (int i = 0; i < budget && sbq.size() > 0; i++) begin
         @(posedge CLK);
         #3;
      end
      if (sbq.size() > 0) begin
         checkOutput("drain_timeout", sbq.size(), 0);
         sbq.delete();
      end
   endtask

   exp_t mon;
   always @(posedge CLK) begin
      #2;
      if (RST_N && result_valid) begin
         if (sbq.size() == 0) begin
            checkOutput("unexpected_rv", 1, 0);
         end else begin
            mon = sbq.pop_front();
            for (int k = 0; k < NUM_TEMPLATES; k++)
               checkOutput($sformatf("sad%0d", k), sad_out[k], mon.sad[k]);
            checkOutput("best_idx", best_idx, mon.idx);
            checkOutput("best_sad", best_sad, mon.best);
            checkOutput("rv_cycle", cyc, mon.cyc);
         end
      end
   end

   task automatic checkAllZero(input string tag);
      for (int k = 0; k < NUM_TEMPLATES; k++)
         checkOutput($sformatf("%s_sad%0d", tag, k), sad_out[k], 0);
      checkOutput({tag, "_best_idx"}, best_idx, 0);
      checkOutput({tag, "_best_sad"}, best_sad, 0);
      checkOutput({tag, "_rv"}, result_valid, 0);
      checkOutput({tag, "_busy"}, busy, 0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, observed timeout, expected completion");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      line_t      img;
      tpl_lines_t tpl;

      #1 RST_N = 1'b0;
      repeat (3) @(negedge CLK);
      checkAllZero("reset");
      RST_N = 1'b1;

      $display("[TB] basic contiguous window");
      img = constLine(100);
      tpl = constTpl(100, 98, 105, 90);
      applyStimulus(img, tpl, 0, 1);
      @(posedge CLK);
      #1 checkOutput("busy_rise", busy, 1);
      for (int i = 0; i < TEMPLATE_ROWS; i++) applyStimulus(img, tpl, 1, 0);
      waitDrain(20);
      checkOutput("busy_hold", busy, 1);
      @(posedge CLK);
      #3 checkOutput("busy_fall", busy, 0);

      $display("[TB] worst case magnitudes");
      img = constLine(255);
      tpl = constTpl(255, 255, 0, 255);
      applyStimulus(img, tpl, 0, 1);
      for (int i = 0; i < TEMPLATE_ROWS; i++) applyStimulus(img, tpl, 1, 0);
      waitDrain(20);

      $display("[TB] gapped line_valid");
      img = constLine(100);
      tpl = constTpl(100, 98, 105, 90);
      applyStimulus(img, tpl, 0, 1);
      for (int i = 0; i < TEMPLATE_ROWS; i++) begin
         applyStimulus(img, tpl, 1, 0);
         applyStimulus(img, tpl, 0, 0);
         applyStimulus(img, tpl, 0, 0);
      end
      waitDrain(20);

      $display("[TB] restart mid-window");
      applyStimulus(img, tpl, 0, 1);
      for (int i = 0; i < 5; i++) applyStimulus(img, tpl, 1, 0);
      img = constLine(50);
      tpl = constTpl(60, 70, 80, 50);
      applyStimulus(img, tpl, 1, 1);
      for (int i = 1; i < TEMPLATE_ROWS; i++) applyStimulus(img, tpl, 1, 0);
      waitDrain(20);

      $display("[TB] reset mid-window");
      img = constLine(100);
      tpl = constTpl(100, 98, 105, 90);
      applyStimulus(img, tpl, 0, 1);
      for (int i = 0; i < 4; i++) applyStimulus(img, tpl, 1, 0);
      #2 RST_N = 1'b0;
      line_valid = 1'b0;
      mActive = 0;
      #1 checkAllZero("midreset");
      @(negedge CLK);
      RST_N = 1'b1;
      for (int i = 0; i < TEMPLATE_ROWS + 2; i++) applyStimulus(img, tpl, 1, 0);
      releaseInputs();
      repeat (8) @(negedge CLK);
      checkOutput("no_start_busy", busy, 0);

      $display("[TB] extra lines beyond window");
      applyStimulus(img, tpl, 0, 1);
      for (int i = 0; i < TEMPLATE_ROWS + 2; i++) begin
         for (int p = 0; p < LINE_SIZE; p++) begin
            img[p] = pixel_t'($urandom_range(0, 255));
            for (int k = 0; k < NUM_TEMPLATES; k++) tpl[k][p] = pixel_t'($urandom_range(0, 255));
         end
         applyStimulus(img, tpl, 1, 0);
      end
      waitDrain(20);
      repeat (6) @(negedge CLK);

      checkOutput("leftover", sbq.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
